// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Provides opcode constants, the 4-bit state encoding, ALUOp codes
// (also consumed by alu_control_unit), ALUSrcB / PCSource select codes,
// and the control-word struct that the output decoder produces.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_word_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational map from FSM state (plus mem_ready, plus opcode for the
// DECODE-only illegal flag) to the datapath control word.
// Ports:
//   state     in  state_t      current FSM state
//   mem_ready in  1            memory completes the current access
//   opcode    in  6            IR[31:26], only looked at in DECODE
//   ctrl      out ctrl_word_t  all strobes and mux selects
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // PC+4 and the IR load only commit once the fetch completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = ALUB_IMM_SH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = !op_supported(opcode);
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.memto_reg = 1'b1;
                ctrl.reg_dst   = 1'b0;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.memto_reg = 1'b0;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b0;
                ctrl.memto_reg = 1'b0;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multicycle MIPS datapath. Holds the state
// register and next-state logic; the control word comes from
// ctrl_output_decode and is forced to zero while rst is high.
// Ports:
//   clk, rst (async, active high)
//   opcode[5:0]  IR[31:26], sampled in DECODE
//   mem_ready    memory completes the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]
//                datapath strobes and selects
//   illegal_op   one-cycle pulse in DECODE for an unsupported opcode
//   state_dbg    current state encoding
//
// state        | meaning
// FETCH     0  | read IR from mem[PC], PC <= PC+4 on mem_ready
// DECODE    1  | precompute branch target, dispatch on opcode
// MEM_ADDR  2  | ALUOut <= rs + signext(imm)
// MEM_READ  3  | load read, waits for mem_ready
// MEM_WB    4  | rt <= MDR
// MEM_WRITE 5  | store write, waits for mem_ready
// EXECUTE   6  | R-type ALU op
// R_WB      7  | rd <= ALUOut
// BRANCH    8  | beq compare, PC <= target if zero
// JUMP      9  | PC <= jump target
// ADDI_EXEC 10 | ALUOut <= rs + signext(imm)
// ADDI_WB   11 | rt <= ALUOut
// 12..15       | unreachable, return to FETCH
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t     state;
    state_t     state_nxt;
    logic       is_store;
    ctrl_word_t ctrl;
    ctrl_word_t ctrl_q;

    // MEM_ADDR must pick read vs write without looking at opcode again,
    // so the load/store choice is captured while in DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FETCH;
            is_store <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                is_store <= (opcode == OP_SW);
            end
        end
    end

    always_comb begin
        state_nxt = ST_FETCH;
        case (state)
            ST_FETCH:     state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
                    OP_RTYPE:     state_nxt = ST_EXECUTE;
                    OP_BEQ:       state_nxt = ST_BRANCH;
                    OP_J:         state_nxt = ST_JUMP;
                    OP_ADDI:      state_nxt = ST_ADDI_EXEC;
                    default:      state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR:  state_nxt = is_store ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  state_nxt = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    state_nxt = ST_FETCH;
            ST_MEM_WRITE: state_nxt = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_EXECUTE:   state_nxt = ST_R_WB;
            ST_R_WB:      state_nxt = ST_FETCH;
            ST_BRANCH:    state_nxt = ST_FETCH;
            ST_JUMP:      state_nxt = ST_FETCH;
            ST_ADDI_EXEC: state_nxt = ST_ADDI_WB;
            ST_ADDI_WB:   state_nxt = ST_FETCH;
            default:      state_nxt = ST_FETCH;
        endcase
    end

    ctrl_output_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    // State is already FETCH during reset, but FETCH drives MemRead, so the
    // whole word is blanked until rst drops.
    assign ctrl_q      = rst ? '0 : ctrl;

    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IRWrite     = ctrl_q.ir_write;
    assign MemtoReg    = ctrl_q.memto_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign illegal_op  = ctrl_q.illegal_op;
    assign state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm. A driver walks each
// instruction through its expected phase list (derived from the opcode and
// chosen stall counts), pushing the expected control word per cycle; a
// monitor pops and compares on every falling edge.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;

    multicycle_control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] act_word();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                PCSource, illegal_op, state_dbg};
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return op == T_R || op == T_LW || op == T_SW ||
               op == T_BEQ || op == T_J || op == T_ADDI;
    endfunction

    // Expected control word for a state number, straight from the
    // per-state output lists; anything unlisted stays 0.
    function automatic logic [20:0] exp_word(input int st, input logic rdy,
                                             input logic ill);
        logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0;
        logic m2r = 0, rdst = 0, rw = 0, asa = 0, il = 0;
        logic [1:0] asb = 0, aop = 0, pcs = 0;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin asb = 2'b11; il = ill; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop,
                pcs, il, 4'(st)};
    endfunction

    task automatic check_now(input string name, input logic [20:0] exp);
        logic [20:0] act;
        act = act_word();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, record what the DUT must show, advance.
    task automatic cyc(input int st, input logic rdy, input logic [5:0] op);
        mem_ready = rdy;
        opcode    = op;
        exp_q.push_back(exp_word(st, rdy, (st == 1) && !legal(op)));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    task automatic run_instr(input logic [5:0] op, input int fstall,
                             input int mstall);
        for (int i = 0; i < fstall; i++) cyc(0, 1'b0, rnd_op());
        cyc(0, 1'b1, rnd_op());
        cyc(1, 1'($urandom), op);
        case (op)
            T_LW: begin
                cyc(2, 1'($urandom), rnd_op());
                for (int i = 0; i < mstall; i++) cyc(3, 1'b0, rnd_op());
                cyc(3, 1'b1, rnd_op());
                cyc(4, 1'($urandom), rnd_op());
            end
            T_SW: begin
                cyc(2, 1'($urandom), rnd_op());
                for (int i = 0; i < mstall; i++) cyc(5, 1'b0, rnd_op());
                cyc(5, 1'b1, rnd_op());
            end
            T_R: begin
                cyc(6, 1'($urandom), rnd_op());
                cyc(7, 1'($urandom), rnd_op());
            end
            T_BEQ:  cyc(8, 1'($urandom), rnd_op());
            T_J:    cyc(9, 1'($urandom), rnd_op());
            T_ADDI: begin
                cyc(10, 1'($urandom), rnd_op());
                cyc(11, 1'($urandom), rnd_op());
            end
            default: ;
        endcase
    endtask

    initial begin : monitor
        logic [20:0] e;
        logic [20:0] a;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = act_word();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle st=%0d: got %h expected %h at %0t",
                             e[3:0], a, e, $time);
                end
            end
        end
    end

    initial begin : driver
        logic [5:0] ops[6];
        logic [5:0] op;
        ops[0] = T_R; ops[1] = T_LW; ops[2] = T_SW;
        ops[3] = T_BEQ; ops[4] = T_J; ops[5] = T_ADDI;

        rst = 1'b1; mem_ready = 1'b1; opcode = T_R;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_hold", 21'd0);
        rst = 1'b0;
        #1;
        check_now("after_release", exp_word(0, 1'b1, 1'b0));
        @(posedge clk); #1;
        check_now("rtype_decode", exp_word(1, 1'b1, 1'b0));
        @(posedge clk); #1;
        check_now("rtype_execute", exp_word(6, 1'b1, 1'b0));
        #2 rst = 1'b1;
        #1;
        check_now("reset_mid_exec", 21'd0);
        #1 rst = 1'b0;
        #1;
        check_now("release_fetch", exp_word(0, 1'b1, 1'b0));
        mem_ready = 1'b0;
        @(posedge clk); #1;

        run_instr(T_LW,   0, 0);
        run_instr(T_R,    0, 0);
        run_instr(T_BEQ,  0, 0);
        run_instr(T_J,    0, 0);
        run_instr(T_SW,   0, 3);
        run_instr(T_ADDI, 0, 0);
        run_instr(T_LW,   2, 1);
        run_instr(6'b111111, 0, 0);
        run_instr(T_R,    2, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 6) == 0) op = rnd_op();
            else op = ops[$urandom_range(0, 5)];
            run_instr(op,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit for the multicycle MIPS datapath. Decodes the 6-bit instruction opcode and sequences each instruction through fetch, decode, execute, memory and write-back states. Drives every datapath strobe and mux select, including the 2-bit `ALUOp` consumed by `alu_control_unit`. Sits between the instruction register and the datapath. A `mem_ready` handshake stalls the sequence on memory accesses.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: `IR[31:26]`, sampled in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load qualified by ALU zero (beq).
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` out 1, `MemWrite` out 1: memory request strobes.
- `IRWrite` out 1: instruction register load.
- `MemtoReg` out 1: register write data; 0 = ALUOut, 1 = MDR.
- `RegDst` out 1: destination register; 0 = rt, 1 = rd.
- `RegWrite` out 1: register file write.
- `ALUSrcA` out 1: ALU A input; 0 = PC, 1 = rs.
- `ALUSrcB` out 2: ALU B input; 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- `ALUOp` out 2: 00 = add, 01 = subtract, 10 = use funct.
- `PCSource` out 2: next PC; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state_dbg` out 4: current state encoding.

## Operation
- Supported opcodes: R-type `000000`, lw `100011`, sw `101011`, beq `000100`, j `000010`, addi `001000`.
- States and encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5, EXECUTE = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EXEC = 10, ADDI_WB = 11.
  - Encodings 12–15 are unreachable and recover to FETCH on the next clock.
- Outputs are Moore: a function of state only, except where gated by `mem_ready`. Every output not listed for a state is 0.
- FETCH:
  - Drives `MemRead` = 1, `IorD` = 0, `ALUSrcA` = 0, `ALUSrcB` = 01, `ALUOp` = 00, `PCSource` = 00.
  - `IRWrite` and `PCWrite` equal `mem_ready`.
  - Holds while `mem_ready` = 0; goes to DECODE when `mem_ready` = 1.
- DECODE:
  - Drives `ALUSrcA` = 0, `ALUSrcB` = 11, `ALUOp` = 00 (branch target precompute).
  - Next state by opcode: lw or sw → MEM_ADDR; R-type → EXECUTE; beq → BRANCH; j → JUMP; addi → ADDI_EXEC.
  - Any other opcode → FETCH, with `illegal_op` = 1 during DECODE.
- MEM_ADDR: `ALUSrcA` = 1, `ALUSrcB` = 10, `ALUOp` = 00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `MemRead` = 1, `IorD` = 1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB: `RegWrite` = 1, `MemtoReg` = 1, `RegDst` = 0. Goes to FETCH.
- MEM_WRITE: `MemWrite` = 1, `IorD` = 1. Holds until `mem_ready`, then goes to FETCH.
- EXECUTE: `ALUSrcA` = 1, `ALUSrcB` = 00, `ALUOp` = 10. Goes to R_WB.
- R_WB: `RegWrite` = 1, `RegDst` = 1, `MemtoReg` = 0. Goes to FETCH.
- BRANCH: `ALUSrcA` = 1, `ALUSrcB` = 00, `ALUOp` = 01, `PCWriteCond` = 1, `PCSource` = 01. Goes to FETCH.
- JUMP: `PCWrite` = 1, `PCSource` = 10. Goes to FETCH.
- ADDI_EXEC: `ALUSrcA` = 1, `ALUSrcB` = 10, `ALUOp` = 00. Goes to ADDI_WB.
- ADDI_WB: `RegWrite` = 1, `RegDst` = 0, `MemtoReg` = 0. Goes to FETCH.

## Timing
- Reset:
  - `rst` = 1 forces state to FETCH immediately (asynchronous).
  - While `rst` is high, all strobes are 0 (`PCWrite`, `PCWriteCond`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`, `illegal_op`), selects are 0, and `state_dbg` = 0.
  - FETCH outputs appear combinationally after `rst` deasserts. The first state advance is on the first rising edge with `rst` = 0.
- Cycle counts with `mem_ready` tied to 1:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Memory stalls: each cycle of `mem_ready` = 0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. All outputs stay stable during the stall, and `IRWrite`/`PCWrite` stay 0.
- `mem_ready` is ignored in every other state.
- `opcode` is sampled only in DECODE. Changes in other states have no effect.
- Reset during any state, including a stall, aborts the instruction; no further strobes issue.

## Structure
- Shared package `mips_ctrl_pkg`: opcode constants, 4-bit state encodings, `ALUOp` codes (`ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_FUNCT`), and `ALUSrcB`/`PCSource` select codes. `alu_control_unit` reuses the `ALUOp` constants.
- One sub-module is natural: `ctrl_output_decode`, a combinational map from state plus `mem_ready` to the control word. The FSM module itself holds only the state register and next-state logic.

## Test plan
- Reset: assert `rst` mid-EXECUTE → `state_dbg` = 0 immediately and all strobes 0. After release, `MemRead` = 1 and `ALUSrcB` = 01.
- lw (`opcode` = `100011`, `mem_ready` = 1) → states 0,1,2,3,4,0 across 5 cycles. `RegWrite` and `MemtoReg` = 1 only in state 4.
- R-type (`000000`) → `ALUOp` = 10 in state 6. `RegWrite` = 1 with `RegDst` = 1 in state 7. Back to FETCH after 4 cycles.
- beq (`000100`) → `ALUOp` = 01, `PCWriteCond` = 1, `PCSource` = 01 in state 8. j (`000010`) → `PCWrite` = 1, `PCSource` = 10 in state 9.
- Stall: sw with `mem_ready` = 0 for 3 cycles in MEM_WRITE → `MemWrite` held high for 4 cycles, then FETCH. Fetch stall of 2 cycles → `IRWrite` pulses only in the ready cycle.
- Illegal `opcode` = `111111` → `illegal_op` = 1 for exactly one cycle in DECODE, then FETCH. No `RegWrite`, `MemWrite` or `PCWrite` issued.
